// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, Cnd evaluation and the E-to-M pipeline register.
// Optional macro CMOV_EN: when defined, icode 2 with a nonzero ifun acts as a conditional move.
module execute_stage #(
    parameter int n = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   e_icode,
    input  logic [3:0]   e_ifun,
    input  logic [3:0]   e_rA,
    input  logic [3:0]   e_rB,
    input  logic [n-1:0] e_valA,
    input  logic [n-1:0] e_valB,
    input  logic [n-1:0] e_valC,
    input  logic         m_bubble,
    input  logic         m_stall,
    input  logic         cc_hold,
    output logic [n-1:0] e_valE_fwd,
    output logic [3:0]   e_dstE_fwd,
    output logic [3:0]   m_icode,
    output logic         m_cnd,
    output logic [n-1:0] m_valE,
    output logic [n-1:0] m_valA,
    output logic [3:0]   m_dstE,
    output logic [3:0]   m_dstM
);
    localparam logic [3:0] I_NOP = 4'h1, I_RRMOV = 4'h2, I_IRMOV = 4'h3, I_RMMOV = 4'h4,
                           I_MRMOV = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7, I_CALL = 4'h8,
                           I_RET = 4'h9, I_PUSH = 4'hA, I_POP = 4'hB;
    localparam logic [3:0] R_NONE = 4'hF, R_RSP = 4'h4;
    localparam logic [n-1:0] EIGHT = n'(8);

    logic [n-1:0] alu_a, alu_b, val_e;
    logic         of_new, cc_we, cond, cnd;
    logic         zf, sf, of;
    logic [3:0]   dst_e, dst_m;

    always_comb begin
        case (e_icode)
            I_RRMOV, I_OPQ:          alu_a = e_valA;
            I_IRMOV, I_RMMOV, I_MRMOV: alu_a = e_valC;
            I_CALL, I_PUSH:          alu_a = -EIGHT;
            I_RET, I_POP:            alu_a = EIGHT;
            default:                 alu_a = '0;
        endcase
        case (e_icode)
            I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b = e_valB;
            default:                                               alu_b = '0;
        endcase
    end

    // Only OPq selects a non-add function; an undefined OPq ifun yields zero.
    always_comb begin
        val_e  = alu_b + alu_a;
        of_new = 1'b0;
        if (e_icode == I_OPQ) begin
            case (e_ifun)
                4'h0: begin
                    val_e  = alu_b + alu_a;
                    of_new = (alu_a[n-1] == alu_b[n-1]) && (val_e[n-1] != alu_a[n-1]);
                end
                4'h1: begin
                    val_e  = alu_b - alu_a;
                    of_new = (alu_a[n-1] != alu_b[n-1]) && (val_e[n-1] != alu_b[n-1]);
                end
                4'h2:    val_e = alu_b & alu_a;
                4'h3:    val_e = alu_b ^ alu_a;
                default: val_e = '0;
            endcase
        end
    end

    assign cc_we = (e_icode == I_OPQ) && (e_ifun <= 4'd3) && !cc_hold;

    // Conditions read the registered CC, so an OPq never sees its own flags.
    always_comb begin
        case (e_ifun)
            4'h0:    cond = 1'b1;
            4'h1:    cond = (sf ^ of) | zf;
            4'h2:    cond = sf ^ of;
            4'h3:    cond = zf;
            4'h4:    cond = ~zf;
            4'h5:    cond = ~(sf ^ of);
            4'h6:    cond = ~(sf ^ of) & ~zf;
            default: cond = 1'b0;
        endcase
        if (e_icode == I_JXX)
            cnd = cond;
        else if (e_icode == I_RRMOV)
`ifdef CMOV_EN
            cnd = cond;
`else
            cnd = 1'b1;
`endif
        else
            cnd = 1'b0;
    end

    always_comb begin
        case (e_icode)
            I_IRMOV, I_OPQ:               dst_e = e_rB;
            I_RRMOV:                      dst_e = cnd ? e_rB : R_NONE;
            I_CALL, I_RET, I_PUSH, I_POP: dst_e = R_RSP;
            default:                      dst_e = R_NONE;
        endcase
        dst_m = (e_icode == I_MRMOV || e_icode == I_POP) ? e_rA : R_NONE;
    end

    assign e_valE_fwd = val_e;
    assign e_dstE_fwd = dst_e;

    always_ff @(posedge clk) begin
        if (reset) begin
            {zf, sf, of} <= 3'b100;
            m_icode <= I_NOP;
            m_cnd   <= 1'b0;
            m_valE  <= '0;
            m_valA  <= '0;
            m_dstE  <= R_NONE;
            m_dstM  <= R_NONE;
        end else begin
            if (cc_we) begin
                zf <= (val_e == '0);
                sf <= val_e[n-1];
                of <= of_new;
            end
            if (!m_stall) begin
                if (m_bubble) begin
                    m_icode <= I_NOP;
                    m_cnd   <= 1'b0;
                    m_valE  <= '0;
                    m_valA  <= '0;
                    m_dstE  <= R_NONE;
                    m_dstM  <= R_NONE;
                end else begin
                    m_icode <= e_icode;
                    m_cnd   <= cnd;
                    m_valE  <= val_e;
                    m_valA  <= e_valA;
                    m_dstE  <= dst_e;
                    m_dstM  <= dst_m;
                end
            end
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Directed table-driven bench for execute_stage: each record drives one cycle and
// lists the expected forwarding outputs and the M register contents after the edge.
module tb_execute_stage;
    localparam logic [63:0] MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [3:0]  F   = 4'hF;
`ifdef CMOV_EN
    localparam bit CM = 1'b1;
`else
    localparam bit CM = 1'b0;
`endif

    typedef struct {
        logic        rst, stl, bub, hold;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] va, vb, vc;
        logic        chk_fwd;
        logic [63:0] f_vale;
        logic [3:0]  f_dste;
        logic [3:0]  x_icode;
        logic        x_cnd;
        logic [63:0] x_vale, x_vala;
        logic [3:0]  x_dste, x_dstm;
    } vec_t;

    logic        clk, reset, m_bubble, m_stall, cc_hold;
    logic [3:0]  e_icode, e_ifun, e_rA, e_rB;
    logic [63:0] e_valA, e_valB, e_valC;
    logic [63:0] e_valE_fwd, m_valE, m_valA;
    logic [3:0]  e_dstE_fwd, m_icode, m_dstE, m_dstM;
    logic        m_cnd;

    int vectors = 0;
    int checks = 0;
    int miscompares = 0;
    vec_t vq[$];

    execute_stage #(.n(64)) dut (
        .clk(clk), .reset(reset),
        .e_icode(e_icode), .e_ifun(e_ifun), .e_rA(e_rA), .e_rB(e_rB),
        .e_valA(e_valA), .e_valB(e_valB), .e_valC(e_valC),
        .m_bubble(m_bubble), .m_stall(m_stall), .cc_hold(cc_hold),
        .e_valE_fwd(e_valE_fwd), .e_dstE_fwd(e_dstE_fwd),
        .m_icode(m_icode), .m_cnd(m_cnd), .m_valE(m_valE), .m_valA(m_valA),
        .m_dstE(m_dstE), .m_dstM(m_dstM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        int idx;
        idx = vectors;
        vectors++;
        reset = v.rst; m_stall = v.stl; m_bubble = v.bub; cc_hold = v.hold;
        e_icode = v.icode; e_ifun = v.ifun; e_rA = v.ra; e_rB = v.rb;
        e_valA = v.va; e_valB = v.vb; e_valC = v.vc;
        #1;
        if (v.chk_fwd) begin
            chk("fwd_valE", idx, e_valE_fwd, v.f_vale);
            chk("fwd_dstE", idx, {60'd0, e_dstE_fwd}, {60'd0, v.f_dste});
        end
        @(posedge clk);
        #1;
        chk("m_icode", idx, {60'd0, m_icode}, {60'd0, v.x_icode});
        chk("m_cnd",   idx, {63'd0, m_cnd},   {63'd0, v.x_cnd});
        chk("m_valE",  idx, m_valE, v.x_vale);
        chk("m_valA",  idx, m_valA, v.x_vala);
        chk("m_dstE",  idx, {60'd0, m_dstE}, {60'd0, v.x_dste});
        chk("m_dstM",  idx, {60'd0, m_dstM}, {60'd0, v.x_dstm});
    endtask

    initial begin
        // rst stl bub hold | icode ifun rA rB | valA valB valC | chk fwdE fwdDst | icode cnd valE valA dstE dstM
        vq.push_back('{1,0,0,0, 4'h6,4'h0,4'h1,4'h2, 64'h5,64'h6,64'h0, 0,64'h0,F, 4'h1,0,64'h0,64'h0,F,F});
        vq.push_back('{0,0,0,0, 4'h7,4'h3,F,F, 64'h33,64'h0,64'h40, 1,64'h0,F, 4'h7,1,64'h0,64'h33,F,F});
        vq.push_back('{0,0,0,0, 4'h6,4'h0,4'h1,4'h3, MAX,64'h1,64'h0, 1,MIN,4'h3, 4'h6,0,MIN,MAX,4'h3,F});
        vq.push_back('{0,0,0,0, 4'h7,4'h2,F,F, 64'h50,64'h0,64'h0, 1,64'h0,F, 4'h7,0,64'h0,64'h50,F,F});
        vq.push_back('{0,0,0,0, 4'h7,4'h5,F,F, 64'h0,64'h0,64'h0, 1,64'h0,F, 4'h7,1,64'h0,64'h0,F,F});
        vq.push_back('{0,0,0,0, 4'h6,4'h1,4'h1,4'h7, 64'h5,64'h5,64'h0, 1,64'h0,4'h7, 4'h6,0,64'h0,64'h5,4'h7,F});
        vq.push_back('{0,0,0,0, 4'h2,4'h3,4'h1,4'h2, 64'hABC,64'h0,64'h0, 1,64'hABC,4'h2, 4'h2,1,64'hABC,64'hABC,4'h2,F});
        vq.push_back('{0,0,0,0, 4'h2,4'h4,4'h1,4'h2, 64'h123,64'h0,64'h0, 1,64'h123,(CM ? F : 4'h2),
                       4'h2,!CM,64'h123,64'h123,(CM ? F : 4'h2),F});
        vq.push_back('{0,0,0,0, 4'h2,4'h0,4'h1,4'h5, 64'h9,64'h0,64'h0, 1,64'h9,4'h5, 4'h2,1,64'h9,64'h9,4'h5,F});
        vq.push_back('{0,0,0,0, 4'hA,4'h0,4'h3,F, 64'h77,64'h100,64'h0, 1,64'hF8,4'h4, 4'hA,0,64'hF8,64'h77,4'h4,F});
        vq.push_back('{0,0,0,0, 4'hB,4'h0,4'h6,F, 64'h0,64'h100,64'h0, 1,64'h108,4'h4, 4'hB,0,64'h108,64'h0,4'h4,4'h6});
        vq.push_back('{0,0,0,0, 4'h6,4'h2,4'h1,4'h8, 64'hF,64'h3,64'h0, 1,64'h3,4'h8, 4'h6,0,64'h3,64'hF,4'h8,F});
        vq.push_back('{0,0,0,1, 4'h6,4'h3,4'h1,4'h1, 64'hF0,64'hF0,64'h0, 1,64'h0,4'h1, 4'h6,0,64'h0,64'hF0,4'h1,F});
        vq.push_back('{0,0,0,0, 4'h7,4'h3,F,F, 64'h60,64'h0,64'h0, 1,64'h0,F, 4'h7,0,64'h0,64'h60,F,F});
        vq.push_back('{0,0,0,0, 4'h6,4'h7,4'h1,4'h9, 64'h1,64'h2,64'h0, 1,64'h0,4'h9, 4'h6,0,64'h0,64'h1,4'h9,F});
        vq.push_back('{0,0,0,0, 4'h7,4'h3,F,F, 64'h61,64'h0,64'h0, 1,64'h0,F, 4'h7,0,64'h0,64'h61,F,F});
        vq.push_back('{0,0,0,0, 4'h3,4'h0,F,4'h4, 64'h0,64'h0,64'h1234, 1,64'h1234,4'h4, 4'h3,0,64'h1234,64'h0,4'h4,F});
        vq.push_back('{0,0,0,0, 4'h5,4'h0,4'h2,4'h3, 64'h0,64'h200,64'h10, 1,64'h210,F, 4'h5,0,64'h210,64'h0,F,4'h2});
        vq.push_back('{0,0,0,0, 4'h8,4'h0,F,F, 64'h500,64'h100,64'h0, 1,64'hF8,4'h4, 4'h8,0,64'hF8,64'h500,4'h4,F});
        vq.push_back('{0,0,0,0, 4'h9,4'h0,F,F, 64'h0,64'hF8,64'h0, 1,64'h100,4'h4, 4'h9,0,64'h100,64'h0,4'h4,F});
        // Two stalled cycles: M holds the ret, while the stalled OPq still sets ZF.
        vq.push_back('{0,1,0,0, 4'h6,4'h1,4'h1,4'h5, 64'h1,64'h1,64'h0, 1,64'h0,4'h5, 4'h9,0,64'h100,64'h0,4'h4,F});
        vq.push_back('{0,1,0,0, 4'h3,4'h0,F,4'h6, 64'h0,64'h0,64'h99, 1,64'h99,4'h6, 4'h9,0,64'h100,64'h0,4'h4,F});
        vq.push_back('{0,0,1,0, 4'h3,4'h0,F,4'h6, 64'h0,64'h0,64'h99, 1,64'h99,4'h6, 4'h1,0,64'h0,64'h0,F,F});
        vq.push_back('{0,0,0,0, 4'h7,4'h3,F,F, 64'h62,64'h0,64'h0, 1,64'h0,F, 4'h7,1,64'h0,64'h62,F,F});
        vq.push_back('{0,1,1,0, 4'h3,4'h0,F,4'h6, 64'h0,64'h0,64'h55, 1,64'h55,4'h6, 4'h7,1,64'h0,64'h62,F,F});
        // Reset beats stall and the CC update of a negative-result sub.
        vq.push_back('{1,1,0,0, 4'h6,4'h1,4'h1,4'h2, 64'h1,64'h0,64'h0, 1,ALL,4'h2, 4'h1,0,64'h0,64'h0,F,F});
        vq.push_back('{0,0,0,0, 4'h7,4'h3,F,F, 64'h63,64'h0,64'h0, 1,64'h0,F, 4'h7,1,64'h0,64'h63,F,F});
        vq.push_back('{0,0,0,0, 4'h6,4'h1,4'h1,4'h0, 64'h1,MIN,64'h0, 1,MAX,4'h0, 4'h6,0,MAX,64'h1,4'h0,F});
        vq.push_back('{0,0,0,0, 4'h7,4'h2,F,F, 64'h64,64'h0,64'h0, 1,64'h0,F, 4'h7,1,64'h0,64'h64,F,F});
        vq.push_back('{0,0,0,0, 4'h7,4'h6,F,F, 64'h65,64'h0,64'h0, 1,64'h0,F, 4'h7,0,64'h0,64'h65,F,F});
        vq.push_back('{0,0,0,0, 4'h7,4'h7,F,F, 64'h66,64'h0,64'h0, 1,64'h0,F, 4'h7,0,64'h0,64'h66,F,F});

        foreach (vq[i]) apply(vq[i]);

        // Hand sequence: cmov immediately after the OPq that sets its flags (SF=1, OF=0).
        apply('{0,0,0,0, 4'h6,4'h1,4'h1,4'h3, 64'h5,64'h3,64'h0, 1,64'hFFFF_FFFF_FFFF_FFFE,4'h3,
                4'h6,0,64'hFFFF_FFFF_FFFF_FFFE,64'h5,4'h3,F});
        apply('{0,0,0,0, 4'h2,4'h2,4'h1,4'h3, 64'h42,64'h0,64'h0, 1,64'h42,4'h3, 4'h2,1,64'h42,64'h42,4'h3,F});
        apply('{0,0,0,0, 4'h2,4'h5,4'h1,4'h3, 64'h43,64'h0,64'h0, 1,64'h43,(CM ? F : 4'h3),
                4'h2,!CM,64'h43,64'h43,(CM ? F : 4'h3),F});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
